// File: rtl/hive_pkg.sv
// Shared types and constants for the hive ALU writeback path.
package hive_pkg;

  localparam int THD_W = 3;
  localparam int REG_W = 3;

  typedef struct packed {
    logic             vld;
    logic [THD_W-1:0] thd;
    logic [REG_W-1:0] dst;
    logic             sat;
    logic             sgn;
  } MS_WB_TAG_T;

  localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;

endpackage

// File: rtl/hive_tag_pipe.sv
// Fixed-depth delay line for issue tags of fixed-latency ALU units.
module hive_tag_pipe
  import hive_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  MS_WB_TAG_T tag_i,
  output MS_WB_TAG_T tag_o
);

  MS_WB_TAG_T stg_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign tag_o = stg_q[DEPTH-1];

endmodule

// File: rtl/hive_alu_mul_shl_wb.sv
// Writeback alignment/saturation stage after the multiply/shift unit.
// Optional overflow event counter: HIVE_MS_WB_OVF_CNT_EN.
module hive_alu_mul_shl_wb
  import hive_pkg::*;
#(
  parameter int ALU_W   = 32,
  parameter int FLG_W   = 4,
  parameter int THREADS = 8,
  parameter int MS_LAT  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               vld_i,
  input  logic [THD_W-1:0]   thd_i,
  input  logic [REG_W-1:0]   dst_i,
  input  logic               sat_i,
  input  logic               sgn_i,
  input  logic [ALU_W-1:0]   result_i,
  input  logic [FLG_W-1:0]   flg_i,
  input  logic               clr_i,
  input  logic [THD_W-1:0]   clr_thd_i,
  output logic               wb_vld_o,
  output logic [THD_W-1:0]   wb_thd_o,
  output logic [REG_W-1:0]   wb_dst_o,
  output logic [ALU_W-1:0]   wb_data_o,
  output logic               wb_ovf_o,
  output logic [THREADS-1:0] ovf_sticky_o,
  output logic [15:0]        ovf_cnt_o
);

  // Tag must be at the pipe output in the cycle the result is valid,
  // i.e. after edge E+MS_LAT, counting the capture edge E itself.
  localparam int TAG_STG = MS_LAT + 1;

  MS_WB_TAG_T       iss_tag;
  MS_WB_TAG_T       mat_tag;
  MS_WB_TAG_T       a_tag_q;
  logic [ALU_W-1:0] a_data_q;

  assign iss_tag = '{
    vld: vld_i,
    thd: thd_i,
    dst: dst_i,
    sat: sat_i,
    sgn: sgn_i
  };

  hive_tag_pipe #(
    .DEPTH (TAG_STG)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .tag_i   (iss_tag),
    .tag_o   (mat_tag)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_tag_q  <= '0;
      a_data_q <= '0;
    end else begin
      a_tag_q  <= mat_tag;
      a_data_q <= result_i;
    end
  end

  logic             ovf_u;
  logic             ovf_s;
  logic             ovf;
  logic [ALU_W-1:0] sat_val;
  logic [ALU_W-1:0] cmb_data;

  always_comb begin
    ovf_u = flg_i[2];
    ovf_s = !((!flg_i[2] && !flg_i[0]) ||
              ( flg_i[1] &&  flg_i[0]));
    ovf   = a_tag_q.sgn ? ovf_s : ovf_u;
    if (a_tag_q.sgn) begin
      sat_val = flg_i[3] ? ALU_W'(SAT_S_MIN)
                         : ALU_W'(SAT_S_MAX);
    end else begin
      sat_val = ALU_W'(SAT_U_MAX);
    end
    cmb_data = (a_tag_q.sat && ovf) ? sat_val : a_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_vld_o  <= 1'b0;
      wb_ovf_o  <= 1'b0;
      wb_thd_o  <= '0;
      wb_dst_o  <= '0;
      wb_data_o <= '0;
    end else begin
      wb_vld_o <= a_tag_q.vld;
      wb_ovf_o <= ovf && a_tag_q.vld;
      if (a_tag_q.vld) begin
        wb_thd_o  <= a_tag_q.thd;
        wb_dst_o  <= a_tag_q.dst;
        wb_data_o <= cmb_data;
      end
    end
  end

  logic [THREADS-1:0] set_vec;
  logic [THREADS-1:0] clr_vec;
  logic [THREADS-1:0] sticky_d;

  // Set is applied after clear so a same-edge collision keeps the bit.
  always_comb begin
    set_vec  = '0;
    clr_vec  = '0;
    if (wb_vld_o && wb_ovf_o) begin
      set_vec = THREADS'(1) << wb_thd_o;
    end
    if (clr_i) begin
      clr_vec = THREADS'(1) << clr_thd_i;
    end
    sticky_d = (ovf_sticky_o & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_sticky_o <= '0;
    end else begin
      ovf_sticky_o <= sticky_d;
    end
  end

`ifdef HIVE_MS_WB_OVF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= {15'd0, wb_ovf_o};
    end else if (wb_ovf_o && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ovf_cnt_o = cnt_q;
`else
  assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hive_alu_mul_shl_wb.sv
// Scoreboard bench for hive_alu_mul_shl_wb.
module tb_hive_alu_mul_shl_wb;
  import hive_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        vld_i;
  logic [2:0]  thd_i;
  logic [2:0]  dst_i;
  logic        sat_i;
  logic        sgn_i;
  logic [31:0] result_i;
  logic [3:0]  flg_i;
  logic        clr_i;
  logic [2:0]  clr_thd_i;
  logic        wb_vld_o;
  logic [2:0]  wb_thd_o;
  logic [2:0]  wb_dst_o;
  logic [31:0] wb_data_o;
  logic        wb_ovf_o;
  logic [7:0]  ovf_sticky_o;
  logic [15:0] ovf_cnt_o;

  always #5 clk = ~clk;

  hive_alu_mul_shl_wb dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .vld_i        (vld_i),
    .thd_i        (thd_i),
    .dst_i        (dst_i),
    .sat_i        (sat_i),
    .sgn_i        (sgn_i),
    .result_i     (result_i),
    .flg_i        (flg_i),
    .clr_i        (clr_i),
    .clr_thd_i    (clr_thd_i),
    .wb_vld_o     (wb_vld_o),
    .wb_thd_o     (wb_thd_o),
    .wb_dst_o     (wb_dst_o),
    .wb_data_o    (wb_data_o),
    .wb_ovf_o     (wb_ovf_o),
    .ovf_sticky_o (ovf_sticky_o),
    .ovf_cnt_o    (ovf_cnt_o)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  thd;
    logic [2:0]  dst;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] res_sched [64];
  logic [3:0]  flg_sched [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Replays the multiply/shift unit: result after E+4, flags after E+5.
  always @(posedge clk) begin
    #1;
    result_i = res_sched[cyc % 64];
    flg_i    = flg_sched[cyc % 64];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wb_vld_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL wb_unexpected: got write thd %0d at cyc %0d want none",
                 wb_thd_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("wb_cyc",  cyc,       e.cyc);
        chk("wb_thd",  wb_thd_o,  e.thd);
        chk("wb_dst",  wb_dst_o,  e.dst);
        chk("wb_data", wb_data_o, e.data);
        chk("wb_ovf",  wb_ovf_o,  e.ovf);
      end
    end
  end

  task automatic issue(input logic [2:0] thd, input logic [2:0] dst,
                       input logic sat, input logic sgn,
                       input logic [31:0] res, input logic [3:0] flg,
                       input logic [31:0] ed, input logic eo);
    int e;
    e = cyc + 1;
    res_sched[(e + 4) % 64] = res;
    flg_sched[(e + 5) % 64] = flg;
    vld_i = 1'b1;
    thd_i = thd;
    dst_i = dst;
    sat_i = sat;
    sgn_i = sgn;
    sb.push_back('{e + 6, thd, dst, ed, eo});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_pulse(input logic [2:0] t);
    clr_i     = 1'b1;
    clr_thd_i = t;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      res_sched[i] = '0;
      flg_sched[i] = '0;
    end
    rst_n_i   = 1'b0;
    vld_i     = 1'b0;
    thd_i     = '0;
    dst_i     = '0;
    sat_i     = 1'b0;
    sgn_i     = 1'b0;
    result_i  = '0;
    flg_i     = '0;
    clr_i     = 1'b0;
    clr_thd_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",    wb_vld_o,     0);
    chk("rst_data",   wb_data_o,    0);
    chk("rst_ovf",    wb_ovf_o,     0);
    chk("rst_sticky", ovf_sticky_o, 0);
    chk("rst_cnt",    ovf_cnt_o,    0);
    rst_n_i = 1'b1;
    idle(2);

    issue(2, 5, 0, 0, 32'h0000_1234, 4'b0000, 32'h0000_1234, 0);
    idle(8);
    issue(1, 1, 1, 1, 32'h1234_5678, 4'b0100, 32'h7FFF_FFFF, 1);
    idle(8);
    chk("sticky_t1", ovf_sticky_o, 8'b0000_0010);

    issue(4, 2, 1, 1, 32'h1234_5678, 4'b1110, 32'h8000_0000, 1);
    issue(6, 3, 1, 0, 32'hCAFE_0001, 4'b0100, 32'hFFFF_FFFF, 1);
    issue(7, 4, 1, 1, 32'h8000_0000, 4'b0111, 32'h8000_0000, 0);
    issue(0, 6, 0, 0, 32'hDEAD_BEEF, 4'b0100, 32'hDEAD_BEEF, 1);
    idle(10);
    chk("sticky_mix", ovf_sticky_o, 8'b0101_0011);

    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 3'(7 - i), 0, 0, 32'h100 + i, 4'b0000,
            32'h100 + i, 0);
    end
    idle(10);
    chk("hold_data", wb_data_o, 32'h107);

    for (int i = 0; i < 3; i++) begin
      issue(3'(i), 3'(i), 1, 0, 32'hA0 + i, 4'b0100, 32'hFFFF_FFFF, 1);
    end
    vld_i   = 1'b0;
    rst_n_i = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    idle(10);
    chk("mid_rst_data",   wb_data_o,    0);
    chk("mid_rst_sticky", ovf_sticky_o, 0);

    issue(3, 3, 0, 0, 32'h0000_0055, 4'b0000, 32'h0000_0055, 0);
    idle(8);

    issue(5, 0, 1, 0, 32'h1, 4'b0100, 32'hFFFF_FFFF, 1);
    issue(3, 1, 1, 0, 32'h2, 4'b0100, 32'hFFFF_FFFF, 1);
    idle(6);
    clr_pulse(3);
    chk("sticky_set_win", ovf_sticky_o, 8'b0010_1000);
    idle(2);
    clr_pulse(3);
    chk("sticky_clr", ovf_sticky_o, 8'b0010_0000);

`ifdef HIVE_MS_WB_OVF_CNT_EN
    idle(4);
    clr_pulse(0);
    chk("cnt_clr0", ovf_cnt_o, 0);
    for (int i = 0; i < 32'h10005; i++) begin
      issue(1, 2, 0, 0, 32'h0, 4'b0100, 32'h0, 1);
    end
    idle(10);
    chk("cnt_sat", ovf_cnt_o, 16'hFFFF);
    clr_pulse(0);
    chk("cnt_clr", ovf_cnt_o, 0);
    issue(2, 2, 0, 0, 32'h0, 4'b0100, 32'h0, 1);
    idle(6);
    clr_pulse(0);
    chk("cnt_clr_inc", ovf_cnt_o, 1);
`else
    chk("cnt_off", ovf_cnt_o, 0);
`endif

    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
    end
    idle(2);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
